// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: start(0), DATA_W data bits LSB-first, even parity, stop(1).
// Line idles high; one word accepted per frame over a valid/ready handshake.
module even_parity_serial_tx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_line,
   output logic              busy,
   output logic              parity_out,
   output logic              frame_done
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]        state;
   logic [BW-1:0]     baud_cnt;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              armed;
   logic              bit_end;
   logic              accept;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign accept  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity_out <= 1'b0;
         armed      <= 1'b0;
      end else begin
         // armed keeps in_ready low until the first edge after reset release
         armed <= 1'b1;
         if (state == IDLE) begin
            baud_cnt <= '0;
            if (accept) begin
               state      <= START;
               shreg      <= in_data;
               parity_out <= ^in_data;
            end
         end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (bit_end) begin
               case (state)
                  START: begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
                  DATA: begin
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_LAST) state <= PARITY;
                  end
                  PARITY:  state <= STOP;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   // Every output is a decode of registered state, so reset forces the line high at once
   always_comb begin
      tx_line = 1'b1;
      case (state)
         START:   tx_line = 1'b0;
         DATA:    tx_line = shreg[0];
         PARITY:  tx_line = parity_out;
         default: tx_line = 1'b1;
      endcase
   end

   assign in_ready   = armed && (state == IDLE);
   assign busy       = (state != IDLE);
   assign frame_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: directed steps, scoreboard of sent words,
// negedge line monitor decoding and parity-checking every frame of the 4-bit instance.
module tb_even_parity_serial_tx;
   localparam int DW_A  = 4;
   localparam int CPB_A = 4;
   localparam int FLEN  = (DW_A + 3) * CPB_A;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] in_data_a = '0;
   logic       in_valid_a = 1'b0;
   logic       rdy_a, tx_a, busy_a, par_a, fd_a;
   logic [7:0] in_data_b = '0;
   logic       in_valid_b = 1'b0;
   logic       rdy_b, tx_b, busy_b, par_b, fd_b;

   even_parity_serial_tx #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
      .in_ready(rdy_a), .tx_line(tx_a), .busy(busy_a), .parity_out(par_a),
      .frame_done(fd_a));

   even_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
      .in_ready(rdy_b), .tx_line(tx_b), .busy(busy_b), .parity_out(par_b),
      .frame_done(fd_b));

   int tests = 0;
   int fails = 0;
   logic [3:0] sb_q[$];
   int frames_seen = 0;
   int fd_cnt = 0;
   int cyc = 0;
   int last_done = 0;
   int last_gap = 0;
   logic [3:0] last_data = '0;
   logic       last_par = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decode one captured frame and compare against the oldest scoreboard entry
   task automatic decode_frame(input logic [FLEN-1:0] smp, input logic [FLEN-1:0] fdv,
                               input logic bsy);
      logic [DW_A+2:0] bits;
      logic            stable;
      logic [3:0]      exp;
      stable = 1'b1;
      for (int g = 0; g < DW_A + 3; g++) begin
         bits[g] = smp[g*CPB_A];
         for (int k = 1; k < CPB_A; k++)
            if (smp[g*CPB_A+k] !== smp[g*CPB_A]) stable = 1'b0;
      end
      chk("bit_stable", stable, 1);
      chk("start_bit", bits[0], 0);
      chk("stop_bit", bits[DW_A+2], 1);
      chk("even_parity", ^bits[DW_A+1:1], 0);
      chk("frame_done_pos", fdv, 32'(1) << (FLEN - 1));
      chk("busy_in_frame", bsy, 1);
      chk("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         chk("data", bits[DW_A:1], exp);
         chk("parity_out", par_a, bits[DW_A+1]);
      end
      last_data = bits[DW_A:1];
      last_par  = bits[DW_A+1];
      frames_seen++;
   endtask

   initial begin
      logic             cap_on;
      int               cap_n;
      logic [FLEN-1:0]  smp;
      logic [FLEN-1:0]  fdv;
      logic             bsy;
      cap_on = 1'b0; cap_n = 0; smp = '0; fdv = '0; bsy = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            cap_on = 1'b0;
            cap_n  = 0;
         end else begin
            if (fd_a === 1'b1) fd_cnt++;
            if (!cap_on && tx_a === 1'b0) begin
               cap_on   = 1'b1;
               cap_n    = 0;
               bsy      = 1'b1;
               last_gap = cyc - last_done - 1;
            end
            if (cap_on) begin
               smp[cap_n] = tx_a;
               fdv[cap_n] = fd_a;
               bsy        = bsy & busy_a;
               cap_n++;
               if (cap_n == FLEN) begin
                  cap_on    = 1'b0;
                  last_done = cyc;
                  decode_frame(smp, fdv, bsy);
               end
            end
         end
      end
   end

   task automatic send(input logic [3:0] d, input logic hold);
      int n;
      in_data_a  = d;
      in_valid_a = 1'b1;
      n = 0;
      while (rdy_a !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", n < 200, 1);
      sb_q.push_back(d);
      @(posedge clk); #1;
      chk("tx_fall_after_accept", tx_a, 0);
      chk("parity_latched", par_a, ^d);
      if (!hold) in_valid_a = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (frames_seen < target && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("frame_timeout", frames_seen >= target, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      int   base;
      int   fd_before;
      int   seen_before;
      logic [10:0] seq;
      logic [10:0] fdb;

      // 1: reset values and idle behaviour
      #1;
      chk("reset_outs", {tx_a, rdy_a, busy_a, par_a, fd_a}, 5'b10000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("ready_before_edge", rdy_a, 0);
      @(posedge clk); #1;
      chk("ready_after_edge", rdy_a, 1);
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || fd_a !== 1'b0 || rdy_a !== 1'b1) ok = 1'b0;
      end
      chk("idle_steady", ok, 1);

      // 2: single frame of 4'b1011
      base = frames_seen;
      send(4'b1011, 1'b0);
      chk("parity_1011", par_a, 1);
      wait_frames(base + 1);
      chk("data_1011", last_data, 4'b1011);
      chk("parbit_1011", last_par, 1);
      chk("parity_holds", par_a, 1);
      chk("idle_after", {tx_a, busy_a, rdy_a}, 3'b101);

      // 3: back-to-back 0000 then 1111 with in_valid held high
      base = frames_seen;
      send(4'b0000, 1'b1);
      in_data_a = 4'b1111;
      send(4'b1111, 1'b0);
      wait_frames(base + 2);
      chk("b2b_gap", last_gap, 1);
      chk("b2b_data2", last_data, 4'b1111);
      chk("b2b_par2", last_par, 0);

      // 4: all 16 words
      base = frames_seen;
      for (int w = 0; w < 16; w++) begin
         send(4'(w), 1'b0);
         wait_frames(base + w + 1);
      end
      chk("exhaustive_count", frames_seen, base + 16);
      chk("sb_drained", sb_q.size(), 0);

      // 5: reset during DATA, then a clean frame
      fd_before   = fd_cnt;
      seen_before = frames_seen;
      send(4'b0110, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      chk("mid_data_low", {busy_a, tx_a}, 2'b10);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", {tx_a, rdy_a, busy_a, fd_a}, 4'b1000);
      repeat (3) @(negedge clk);
      chk("no_done_on_abort", fd_cnt, fd_before);
      chk("no_frame_on_abort", frames_seen, seen_before);
      sb_q.delete();
      rst_n = 1'b1;
      base = frames_seen;
      send(4'b0001, 1'b0);
      wait_frames(base + 1);
      chk("post_reset_data", last_data, 4'b0001);
      chk("post_reset_par", last_par, 1);

      // 6: DATA_W=8, CLKS_PER_BIT=1, 8'hA5
      in_data_b  = 8'hA5;
      in_valid_b = 1'b1;
      begin
         int n;
         n = 0;
         while (rdy_b !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("b_accept_timeout", n < 50, 1);
      end
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      chk("b_parity", par_b, 0);
      for (int i = 0; i < 11; i++) begin
         seq[i] = tx_b;
         fdb[i] = fd_b;
         @(posedge clk); #1;
      end
      chk("b_sequence", seq, 11'b10101001010);
      chk("b_frame_done", fdb, 11'h400);
      chk("b_idle_after", {tx_b, busy_b}, 2'b10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/even_parity_serial_tx.md
Name: even_parity_serial_tx

Overview:
Serial transmitter that takes a DATA_W-bit word over a valid/ready handshake and sends it on a single line as a framed bit stream with a generated even-parity bit. It is the sending end of the team's even-parity link, and the even-parity checker sits at the receiving end. Frame format: start bit (0), data LSB-first, even-parity bit, stop bit (1). The line idles high.

Parameters:
DATA_W, 4, payload width in bits (minimum 1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_line (minimum 1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word (high only in IDLE)
tx_line  output  1  serial output; idles high
busy  output  1  high while a frame is in flight (START through STOP)
parity_out  output  1  even-parity bit of the word currently latched
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - tx_line=1, in_ready=0, busy=0, parity_out=0, frame_done=0.
  - State is IDLE; bit and baud counters are 0.
  - in_ready rises on the first clock edge after rst_n deasserts.
- All outputs are registered or decoded directly from state registers. There is no combinational path from inputs to outputs.
- Handshake:
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - On that edge: in_data goes into a shift register, and parity_out is set to the XOR-reduction of in_data.
  - The sum of ones in data plus parity is therefore always even.
  - in_valid while in_ready=0 is ignored; nothing is queued.
- States and exit conditions:
  - IDLE: tx_line=1, in_ready=1. On accept, go to START.
  - START: tx_line=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_line=shreg[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_W bits, go to PARITY.
  - PARITY: tx_line=parity_out for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Then go to IDLE.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - The bit counter is $clog2(DATA_W+1) bits wide and cleared on entry to DATA.
- Latency:
  - tx_line falls on the cycle after the accepting edge.
  - Frame duration is (DATA_W+3)*CLKS_PER_BIT cycles, measured from the first low cycle to the last stop cycle inclusive.
- Back-to-back frames:
  - in_ready is high the cycle after frame_done.
  - An accept on that cycle puts the next start bit on the line one cycle later, so the minimum idle gap is 1 cycle.
- Stability:
  - in_data changes after the accept have no effect on the current frame.
  - parity_out holds its value until the next accept.
- Reset mid-frame: tx_line returns high immediately (asynchronously) and the frame is abandoned. No frame_done pulse is produced.
- CLKS_PER_BIT=1: each state lasts exactly one cycle per bit, and the same rules apply.

Test Plan:
1. Reset release, in_valid=0 -> tx_line=1, busy=0, frame_done=0 indefinitely. in_ready=1 from the first edge after release.
2. DATA_W=4, CLKS_PER_BIT=4, send 4'b1011 -> line sequence, 4 cycles each: 0, 1, 1, 0, 1, then parity 1, then stop 1.
   - parity_out=1.
   - 28-cycle frame; frame_done pulses at cycle 28.
3. Send 4'b0000, then 4'b1111 back-to-back, with in_valid held high:
   - Parity bits are 0 and 0.
   - Second accept occurs the cycle after the first frame_done, giving a 1-cycle idle gap.
   - in_data changed during the first frame does not alter its bits.
4. Exhaustively send all 16 words through a bench-side even-parity checker:
   - The checker reports even parity on every frame.
   - Decoded data equals the sent data.
5. Assert rst_n=0 mid-DATA while sending 4'b0110:
   - tx_line=1 asynchronously; no frame_done.
   - After release, sending 4'b0001 produces a correct frame with parity 1.
6. CLKS_PER_BIT=1, DATA_W=8, send 8'hA5 -> 11-cycle frame, parity 0, bits LSB-first: 1,0,1,0,0,1,0,1.
